median_window_ctrl: RTL and testbench

Raster-scan sequencer for the 3x3 `filter` median datapath. Accepts one frame of 8-bit pixels in raster order, keeps two line buffers plus a 3x3 window register, and issues one `filter` evaluation per interior pixel. It captures `out_mid` at a fixed cycle offset and streams the (IMG_W-2)x(IMG_H-2) interior medians out in raster order. Sits between the pixel source and the `filter` instance.

---
 rtl/median_window_ctrl.sv | 169 ++++++++++++++++
 tb/tb_median_window_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_ctrl.sv
// Raster-scan sequencer feeding a 3x3 median filter: two line buffers, a 3x3 window and a fixed-offset result capture.
// Optional feature macro: MEDIAN_BYPASS_EN (adds a per-pixel bypass input that routes the window centre to out_pix).
module median_window_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
`ifdef MEDIAN_BYPASS_EN
    input  logic       bypass,
`endif
    output logic       pix_ready,
    output logic [7:0] win_0,
    output logic [7:0] win_1,
    output logic [7:0] win_2,
    output logic [7:0] win_3,
    output logic [7:0] win_4,
    output logic [7:0] win_5,
    output logic [7:0] win_6,
    output logic [7:0] win_7,
    output logic [7:0] win_8,
    output logic       flt_enable,
    input  logic [7:0] flt_mid,
    output logic [7:0] out_pix,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    drain_cnt;
    logic [7:0]    lb0 [IMG_W];
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    win [9];

    logic       accept, complete, last_pix, byp_in;
    logic       v1, v2, l1, l2, b1, b2;
    logic [7:0] ctr2;

`ifdef MEDIAN_BYPASS_EN
    assign byp_in = bypass;
`else
    assign byp_in = 1'b0;
`endif

    // Acceptance depends only on the registered state so it never loops through the FSM logic.
    assign accept   = pix_valid && (state == RUN);
    assign complete = (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix = accept && (row == ROW_MAX) && (col == COL_MAX);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                pix_ready = 1'b1;
                busy      = 1'b1;
                if (last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'd2) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= 2'd0;
            for (int i = 0; i < 9; i++) win[i] <= 8'd0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            b1        <= 1'b0;
            b2        <= 1'b0;
            ctr2      <= 8'd0;
            out_pix   <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // New column enters on the right; top row comes from the older line buffer.
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win[3*i]   <= win[3*i+1];
                    win[3*i+1] <= win[3*i+2];
                end
                win[2] <= lb1[col];
                win[5] <= lb0[col];
                win[8] <= pix_in;
            end

            // Fixed-offset pipeline: issue, filter register, capture.
            v1 <= accept && complete;
            l1 <= last_pix;
            b1 <= byp_in;
            v2 <= v1;
            l2 <= v1 && l1;
            b2 <= b1;
            ctr2 <= win[4];

            out_valid <= v2;
            out_last  <= v2 && l2;
            if (v2) out_pix <= b2 ? ctr2 : flt_mid;
        end
    end

    // NOTE: line buffers are plain RAM without reset; rows 0-1 of each frame overwrite them before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
        end
    end

    assign flt_enable = v1 && !b1;

    assign win_0 = win[0];
    assign win_1 = win[1];
    assign win_2 = win[2];
    assign win_3 = win[3];
    assign win_4 = win[4];
    assign win_5 = win[5];
    assign win_6 = win[6];
    assign win_7 = win[7];
    assign win_8 = win[8];

endmodule

// File: tb/tb_median_window_ctrl.sv
// Self-checking bench for median_window_ctrl (4x4 frames) with a behavioural median filter and a result scoreboard.
`timescale 1ns/1ps
module tb_median_window_ctrl;

    localparam int W = 4;
    localparam int H = 4;
`ifdef MEDIAN_BYPASS_EN
    localparam bit HAS_BYP = 1'b1;
`else
    localparam bit HAS_BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, pix_valid;
    logic [7:0] pix_in;
`ifdef MEDIAN_BYPASS_EN
    logic       bypass;
`endif
    logic       pix_ready, flt_enable, out_valid, out_last, busy, frame_done;
    logic [7:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic [7:0] flt_mid = 8'd0;
    logic [7:0] out_pix;

    median_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef MEDIAN_BYPASS_EN
        .bypass(bypass),
`endif
        .pix_ready(pix_ready),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
        .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
        .flt_enable(flt_enable), .flt_mid(flt_mid), .out_pix(out_pix),
        .out_valid(out_valid), .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        bit         last;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0;
    int         cyc = 0;
    int         fe_cnt = 0, fd_cnt = 0, fd_cyc = 0, out_cnt = 0, last_acc = 0;
    logic [7:0] img [H][W];
    logic [7:0] fw [9];

    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] a [9];
        logic [7:0] t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: registers the median on the enable edge.
    always @(posedge clk) begin
        if (flt_enable) begin
            fw = '{win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8};
            flt_mid <= med9(fw);
        end
    end

    always @(negedge clk) begin
        if (flt_enable) fe_cnt++;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (out_valid) begin
            exp_t e;
            out_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got out_pix=%0d at cyc %0d want none", out_pix, cyc);
            end else begin
                e = sb.pop_front();
                if (out_pix !== e.val) begin
                    errors++;
                    $display("FAIL out_pix got %0d want %0d", out_pix, e.val);
                end
                checks++;
                if (out_last !== e.last) begin
                    errors++;
                    $display("FAIL out_last got %0b want %0b", out_last, e.last);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL out_latency got cyc %0d want cyc %0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic [7:0] pix_of(input int kind, input int r, input int c);
        if (kind == 0) return 8'(r * W + c);
        return (r == 1 && c == 1) ? 8'd255 : 8'd0;
    endfunction

    task automatic drive_one(input int r, input int c, input logic [7:0] v, input bit byp, input bit st);
        int         guard;
        logic [7:0] wv [9];
        exp_t       e;
        @(negedge clk);
        pix_in = v; pix_valid = 1'b1; start = st;
`ifdef MEDIAN_BYPASS_EN
        bypass = byp;
`endif
        guard = 0;
        while (!pix_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!pix_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got pix_ready=%0b want 1", pix_ready);
        end else begin
            img[r][c] = v;
            last_acc  = cyc;
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) wv[k] = img[r-2+k/3][c-2+k%3];
                e.val  = (HAS_BYP && byp) ? img[r-1][c-1] : med9(wv);
                e.last = (r == H-1 && c == W-1);
                e.cyc  = cyc + 3;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        pix_valid = 1'b0; start = 1'b0;
`ifdef MEDIAN_BYPASS_EN
        bypass = 1'b0;
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // kind 0 = ramp, 1 = impulse, 2 = impulse with bypass on (2,2); start_at >= 0 pulses start mid-frame.
    task automatic run_frame(input string name, input int kind, input bit gap, input int start_at, input int exp_fe);
        int guard;
        fe_cnt = 0; fd_cnt = 0; out_cnt = 0;
        pulse_start();
        for (int i = 0; i < W * H; i++) begin
            if (gap && i > 0) idle_cycle();
            drive_one(i / W, i % W, pix_of(kind, i / W, i % W),
                      (kind == 2) && (i == 2 * W + 2), i == start_at);
        end
        idle_cycle();
        guard = 0;
        while (fd_cnt == 0 && guard < 30) begin @(negedge clk); guard++; end
        repeat (3) @(negedge clk);
        checks++;
        if (fd_cnt !== 1) begin errors++; $display("FAIL %s frame_done_count got %0d want 1", name, fd_cnt); end
        checks++;
        if (fd_cyc !== last_acc + 4) begin errors++; $display("FAIL %s frame_done_cycle got %0d want %0d", name, fd_cyc, last_acc + 4); end
        checks++;
        if (out_cnt !== 4) begin errors++; $display("FAIL %s out_count got %0d want 4", name, out_cnt); end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL %s pending_results got %0d want 0", name, sb.size()); end
        checks++;
        if (fe_cnt !== exp_fe) begin errors++; $display("FAIL %s flt_enable_count got %0d want %0d", name, fe_cnt, exp_fe); end
        checks++;
        if (busy !== 1'b0 || pix_ready !== 1'b0) begin
            errors++; $display("FAIL %s idle_flags got busy=%0b pix_ready=%0b want 0 0", name, busy, pix_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
`ifdef MEDIAN_BYPASS_EN
        bypass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_ready, busy, flt_enable, out_valid, out_last, frame_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {pix_ready, busy, flt_enable, out_valid, out_last, frame_done});
        end
        checks++;
        if (out_pix !== 8'd0 || win_0 !== 8'd0 || win_4 !== 8'd0 || win_8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_data got out_pix=%0d win_0=%0d win_4=%0d win_8=%0d want 0", out_pix, win_0, win_4, win_8);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        run_frame("ramp", 0, 1'b0, -1, 4);
    endtask

    task automatic test_impulse();
        run_frame("impulse", 1, 1'b0, -1, 4);
    endtask

    task automatic test_gaps();
        run_frame("gaps", 0, 1'b1, -1, 4);
    endtask

    task automatic test_reset_abort();
        pulse_start();
        for (int i = 0; i < 2 * W + 3; i++) drive_one(i / W, i % W, pix_of(0, i / W, i % W), 1'b0, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0; rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        fe_cnt = 0; out_cnt = 0;
        repeat (6) @(negedge clk);
        checks++;
        if (out_cnt !== 0 || fe_cnt !== 0) begin
            errors++; $display("FAIL abort_stale got out=%0d flt_enable=%0d want 0 0", out_cnt, fe_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%0b want 0", busy); end
        run_frame("after_abort", 0, 1'b0, -1, 4);
    endtask

    task automatic test_start_in_run();
        run_frame("start_in_run", 0, 1'b0, 6, 4);
    endtask

    task automatic test_bypass();
        run_frame("bypass", 2, 1'b0, -1, HAS_BYP ? 3 : 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp();
        test_impulse();
        test_gaps();
        test_reset_abort();
        test_start_in_run();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
